// File: rtl/load_store_unit_pkg.sv
// Shared RV32 definitions for the load/store unit: FSM states, funct3 codes
// and access-size decoding.
package rv32_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Reserved encodings fall into the word size, matching load extraction.
  function automatic lsu_size_t access_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (access_size(f3))
      SZ_HALF: return lo[0];
      SZ_WORD: return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-bus request/acknowledge interface between the load/store unit and memory.
interface load_store_unit_if;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_addr, bus_wdata, bus_sel, bus_read, bus_write,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_sel, bus_read, bus_write,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/load_store_unit_load_format.sv
// Load-path lane extraction: picks the byte/half addressed by addr_lo and
// sign- or zero-extends it according to funct3.
module lsu_load_format
  import rv32_pkg::*;
(
  input  logic [31:0] bus_rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = bus_rdata[{addr_lo, 3'b000} +: 8];
    lane_h = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (funct3)
      F3_B:    load_word = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_word = {24'h0, lane_b};
      F3_H:    load_word = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_word = {16'h0, lane_h};
      default: load_word = bus_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory stage: one bus transaction per load/store, pipeline stall while
// it runs, timeout abort, store lane replication and load formatting.
module load_store_unit
  import rv32_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic [2:0]                funct3,
  input  logic [31:0]               addr,
  input  logic [31:0]               store_data,
  load_store_unit_if.master         bus,
  output logic [31:0]               load_data,
  output logic                      stall,
  output logic                      misaligned,
  output logic                      bus_err
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  lsu_state_t  state;
  logic [7:0]  wait_cnt;
  logic        is_write;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  sel_q;

  logic        req;
  logic        bad_align;
  logic        accept;
  logic        timed_out;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_sel;
  logic [31:0] fmt_word;

  always_comb begin
    req       = mem_read | mem_write;
    bad_align = is_misaligned(funct3, addr[1:0]);
    accept    = (state == IDLE) && req && !bad_align;
    timed_out = (state == BUSY) && !bus.bus_ack && ((wait_cnt + 8'd1) == TIMEOUT_CNT);
    // Held low during reset so the core never sees a stall from a stale request.
    stall      = !rst && ((state == BUSY) || accept);
    misaligned = !rst && (state == IDLE) && req && bad_align;
  end

  // Lanes are computed from the request and captured at accept, so bus outputs
  // never depend combinationally on addr.
  always_comb begin
    lane_wdata = store_data;
    lane_sel   = 4'b1111;
    if (mem_write) begin
      case (access_size(funct3))
        SZ_BYTE: begin
          lane_wdata = {4{store_data[7:0]}};
          lane_sel   = 4'b0001 << addr[1:0];
        end
        SZ_HALF: begin
          lane_wdata = {2{store_data[15:0]}};
          lane_sel   = 4'b0011 << addr[1:0];
        end
        default: ;
      endcase
    end
  end

  lsu_load_format u_load_format (
    .bus_rdata (bus.bus_rdata),
    .addr_lo   (lo_q),
    .funct3    (f3_q),
    .load_word (fmt_word)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= 8'd0;
      is_write  <= 1'b0;
      f3_q      <= 3'd0;
      lo_q      <= 2'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      sel_q     <= 4'd0;
      load_data <= 32'd0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            is_write <= mem_write;
            f3_q     <= funct3;
            lo_q     <= addr[1:0];
            addr_q   <= {addr[31:2], 2'b00};
            wdata_q  <= lane_wdata;
            sel_q    <= lane_sel;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (bus.bus_ack) begin
            if (!is_write) load_data <= fmt_word;
            wait_cnt <= 8'd0;
            state    <= DONE;
          end else if (timed_out) begin
            if (!is_write) load_data <= 32'd0;
            bus_err  <= 1'b1;
            wait_cnt <= 8'd0;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_sel   = sel_q;
  assign bus.bus_read  = (state == BUSY) && !is_write;
  assign bus.bus_write = (state == BUSY) && is_write;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory stage directly downstream of the ALU. It takes the ALU result as the effective address and the rs2 value as store data, runs one request/acknowledge transaction on the data bus per load or store, and stalls the core until that transaction finishes. Byte/halfword lanes are handled on the way out (store replication, byte selects) and on the way back (load extraction, sign/zero extension). The formatted load value goes to the writeback mux.

## Interface
- `TIMEOUT`, default 16: maximum BUSY cycles without `bus_ack` before the access aborts with `bus_err`; legal range 1..255.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_read` in 1: load request from decode.
- `mem_write` in 1: store request from decode.
- `funct3` in 3: access size and sign; same encoding as the RV32I load/store `funct3` field.
- `addr` in 32: effective address, the ALU `result`.
- `store_data` in 32: rs2 value.
- `bus_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_sel` out 4: byte enables.
- `bus_read` out 1: read strobe.
- `bus_write` out 1: write strobe.
- `bus_rdata` in 32: read data; sampled only when `bus_ack`=1.
- `bus_ack` in 1: transaction complete.
- `load_data` out 32: formatted load result for writeback.
- `stall` out 1: holds the PC and pipeline registers.
- `misaligned` out 1: one-cycle misaligned-access flag.
- `bus_err` out 1: one-cycle timeout flag.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE, no request: stays in IDLE, `stall`=0.
- IDLE, aligned request (`mem_read|mem_write`):
  - Latches addr, store_data, funct3 and direction; moves to BUSY.
  - `stall`=1, combinational, in this same cycle.
- If `mem_read` and `mem_write` are both 1, the access is treated as a write.
- Misaligned request, checked in IDLE:
  - Halfword with `addr[0]`=1, or word with `addr[1:0]`≠0, is misaligned.
  - Result: `misaligned`=1 for that cycle, no bus activity, `stall`=0, FSM stays in IDLE, `load_data` unchanged.
- BUSY:
  - `bus_read` or `bus_write` is held high, with `bus_addr`, `bus_wdata` and `bus_sel` driven from the latched registers; `stall`=1.
  - On `bus_ack`: the formatted `bus_rdata` is registered into `load_data` (loads only), the timeout counter clears, and the FSM moves to DONE.
  - Timeout counter increments on each BUSY cycle without `bus_ack`. When it reaches `TIMEOUT`: strobes drop, `bus_err`=1 for one cycle (registered with the move), `load_data`←0 for loads, and the FSM moves to DONE.
  - If `bus_ack` arrives in the same cycle the counter reaches `TIMEOUT`, `bus_ack` wins.
- DONE: `stall`=0, and requests are ignored because the pipeline advances at the end of this cycle. Unconditional move to IDLE.
- Store lanes:
  - SB: `bus_wdata`={4{sd[7:0]}}, `bus_sel`=4'b0001<<addr[1:0].
  - SH: `bus_wdata`={2{sd[15:0]}}, `bus_sel`=4'b0011<<addr[1:0].
  - SW: `bus_wdata`=sd, `bus_sel`=4'b1111.
- Load extraction:
  - Byte or half is selected by `addr[1:0]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Reserved `funct3` values (011, 110, 111) are treated as word.
  - Loads drive `bus_sel`=4'b1111.
- `load_data` holds its value until the next load completes; stores do not modify it.

## Timing
- Reset values:
  - State IDLE, timeout counter 0.
  - `load_data`=0, `bus_addr`=0, `bus_wdata`=0, `bus_sel`=0.
  - `bus_read`, `bus_write`, `bus_err`, `misaligned`, `stall` all 0.
- Reset is asynchronous: it drops bus strobes immediately, and the in-flight transaction is abandoned without a completion.
- Cycle sequence for an ack on the first BUSY cycle:
  - Cycle 0 (IDLE): request accepted, `stall`=1.
  - Cycle 1 (BUSY): strobe high, `bus_ack` seen.
  - Cycle 2 (DONE): `load_data` valid, `stall`=0.
- Minimum stall is 2 cycles; each extra wait cycle adds one.
- Bus outputs come only from registers or decode of registers, never from combinational paths through `addr`.
- `bus_ack` outside BUSY is ignored.
- Worst case, an access occupies `TIMEOUT`+2 cycles.

## Structure
- Shared `rv32_pkg` holds:
  - `lsu_state_t` {IDLE, BUSY, DONE}.
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
- One combinational sub-module, `lsu_load_format`, with inputs (`bus_rdata`, `addr[1:0]`, `funct3`) and output the formatted word. It is unit-tested on its own.
- Top level contains the FSM, the latch registers, the timeout counter and the store lane logic.

## Test plan
- LW at 0x100, `bus_rdata`=0xDEADBEEF, ack on first BUSY cycle:
  - `bus_addr`=0x100, `bus_sel`=4'hF.
  - `stall` high for 2 cycles.
  - `load_data`=0xDEADBEEF in DONE.
- LB at 0x103 and LBU at 0x103, `bus_rdata`=0x80FF0011:
  - LB gives `load_data`=0xFFFFFF80.
  - LBU gives 0x00000080.
  - LH at 0x102 gives 0xFFFF80FF.
- SH at 0x106, `store_data`=0x1234ABCD:
  - `bus_addr`=0x104, `bus_wdata`=0xABCDABCD, `bus_sel`=4'b1100, `bus_write` held high through 3 wait cycles until ack.
  - `load_data` unchanged.
- SW at 0x102:
  - `misaligned` pulses for 1 cycle, `stall`=0.
  - No `bus_write`; FSM remains IDLE.
- LW with `bus_ack` never asserted, `TIMEOUT`=4:
  - `bus_read` high for 4 cycles, then `bus_err` pulses.
  - `load_data`=0, `stall` released in DONE.
  - An ack arriving in the same cycle as the counter reaching `TIMEOUT` completes normally with no `bus_err`.
- Reset asserted mid-BUSY:
  - `bus_read`/`bus_write` drop before the next edge.
  - All outputs return to their reset values.
  - A new LW after release completes normally.
